// File: rtl/silife_pkg.sv
// Shared definitions for the silife grid blocks: grant encodings and the
// generation-period clamp.
package silife_pkg;

    localparam logic [1:0] GrantNone   = 2'd0;
    localparam logic [1:0] GrantLoader = 2'd1;
    localparam logic [1:0] GrantEvolve = 2'd2;
    localparam logic [1:0] GrantBus    = 2'd3;

    localparam int PeriodBits = 16;

    // A period of zero would never wrap, so it behaves as a period of one.
    function automatic logic [PeriodBits-1:0] clamp_period(input logic [PeriodBits-1:0] period);
        return (period == '0) ? PeriodBits'(1) : period;
    endfunction

endpackage

// File: rtl/silife_gen_timer.sv
// Free-running generation timer: counts enabled cycles, raises a request on
// wrap and merges in the single-step pulse.
module silife_gen_timer
    import silife_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_enable,
    input  logic [PeriodBits-1:0] i_period,
    input  logic                  i_step,
    output logic                  o_gen_req
);

    logic [PeriodBits-1:0] count_reg;
    logic [PeriodBits-1:0] period_eff;
    logic                  at_wrap;
    logic                  due;

    assign period_eff = clamp_period(i_period);
    // ">=" rather than "==" so a shortened period wraps on the next enabled cycle.
    assign at_wrap    = (count_reg >= (period_eff - PeriodBits'(1)));
    assign due        = i_enable && at_wrap;
    assign o_gen_req  = due || i_step;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (i_enable) begin
            count_reg <= at_wrap ? '0 : count_reg + PeriodBits'(1);
        end
    end

endmodule

// File: rtl/silife_grid_scheduler.sv
// Arbitrates the grid write port between the SPI loader, the bus writer and
// generation strobes; every grid-facing output is registered.
module silife_grid_scheduler
    import silife_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int HEIGHT   = 32,
    parameter int ROW_BITS = $clog2(HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ROW_BITS-1:0]   i_ld_row,
    input  logic [WIDTH-1:0]      i_ld_set,
    input  logic [WIDTH-1:0]      i_ld_clear,
    input  logic                  i_bus_valid,
    output logic                  o_bus_ready,
    input  logic [ROW_BITS-1:0]   i_bus_row,
    input  logic [WIDTH-1:0]      i_bus_set,
    input  logic [WIDTH-1:0]      i_bus_clear,
    input  logic                  i_enable,
    input  logic [PeriodBits-1:0] i_period,
    input  logic                  i_step,
    input  logic                  i_clear_overrun,
    output logic [ROW_BITS-1:0]   o_row_select,
    output logic [WIDTH-1:0]      o_set_cells,
    output logic [WIDTH-1:0]      o_clear_cells,
    output logic                  o_evolve,
    output logic                  o_overrun,
    output logic [1:0]            o_grant
);

    logic                gen_req;
    logic                ld_active;
    logic                wrote_last;
    logic                evolve_go;
    logic                bus_fire;

    logic                pending_reg, pending_next;
    logic                overrun_reg, overrun_next;
    logic [ROW_BITS-1:0] row_reg, row_next;
    logic [WIDTH-1:0]    set_reg, set_next;
    logic [WIDTH-1:0]    clear_reg, clear_next;
    logic                evolve_reg, evolve_next;
    logic [1:0]          grant_reg, grant_next;

    silife_gen_timer u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_enable  (i_enable),
        .i_period  (i_period),
        .i_step    (i_step),
        .o_gen_req (gen_req)
    );

    assign ld_active  = (|i_ld_set) || (|i_ld_clear);
    // Only actual transfers are recorded as write grants, so this is "port written last cycle".
    assign wrote_last = (grant_reg == GrantLoader) || (grant_reg == GrantBus);
    assign evolve_go  = !ld_active && pending_reg && !wrote_last;
    assign o_bus_ready = reset_n && !ld_active && !(pending_reg && !wrote_last);
    assign bus_fire   = i_bus_valid && o_bus_ready;

    always_comb begin
        row_next     = row_reg;
        set_next     = '0;
        clear_next   = '0;
        evolve_next  = 1'b0;
        grant_next   = GrantNone;
        pending_next = pending_reg;

        if (ld_active) begin
            row_next   = i_ld_row;
            set_next   = i_ld_set & ~i_ld_clear;
            clear_next = i_ld_clear;
            grant_next = GrantLoader;
        end else if (evolve_go) begin
            evolve_next  = 1'b1;
            grant_next   = GrantEvolve;
            pending_next = 1'b0;
        end else if (bus_fire) begin
            row_next   = i_bus_row;
            set_next   = i_bus_set & ~i_bus_clear;
            clear_next = i_bus_clear;
            grant_next = GrantBus;
        end

        // A request arriving as the pending one is consumed re-arms pending and flags overrun.
        if (gen_req) begin
            pending_next = 1'b1;
        end

        if (i_clear_overrun) begin
            overrun_next = 1'b0;
        end else begin
            overrun_next = overrun_reg || (gen_req && pending_reg);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_reg <= 1'b0;
            overrun_reg <= 1'b0;
            row_reg     <= '0;
            set_reg     <= '0;
            clear_reg   <= '0;
            evolve_reg  <= 1'b0;
            grant_reg   <= GrantNone;
        end else begin
            pending_reg <= pending_next;
            overrun_reg <= overrun_next;
            row_reg     <= row_next;
            set_reg     <= set_next;
            clear_reg   <= clear_next;
            evolve_reg  <= evolve_next;
            grant_reg   <= grant_next;
        end
    end

    assign o_row_select  = row_reg;
    assign o_set_cells   = set_reg;
    assign o_clear_cells = clear_reg;
    assign o_evolve      = evolve_reg;
    assign o_overrun     = overrun_reg;
    assign o_grant       = grant_reg;

endmodule

// File: tb/tb_silife_grid_scheduler.sv
// Randomized and directed bench for silife_grid_scheduler against a
// cycle-level reference model of the arbitration and timer rules.
module tb_silife_grid_scheduler;

    localparam int W  = 32;
    localparam int RB = 5;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [RB-1:0] ld_row, bus_row;
    logic [W-1:0]  ld_set, ld_clear, bus_set, bus_clear;
    logic          bus_valid, enable, step, clr_ovr;
    logic [15:0]   period;

    logic          o_bus_ready, o_evolve, o_overrun;
    logic [RB-1:0] o_row_select;
    logic [W-1:0]  o_set_cells, o_clear_cells;
    logic [1:0]    o_grant;

    always #5 clk = ~clk;

    silife_grid_scheduler #(.WIDTH(W), .HEIGHT(32)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_ld_row        (ld_row),
        .i_ld_set        (ld_set),
        .i_ld_clear      (ld_clear),
        .i_bus_valid     (bus_valid),
        .o_bus_ready     (o_bus_ready),
        .i_bus_row       (bus_row),
        .i_bus_set       (bus_set),
        .i_bus_clear     (bus_clear),
        .i_enable        (enable),
        .i_period        (period),
        .i_step          (step),
        .i_clear_overrun (clr_ovr),
        .o_row_select    (o_row_select),
        .o_set_cells     (o_set_cells),
        .o_clear_cells   (o_clear_cells),
        .o_evolve        (o_evolve),
        .o_overrun       (o_overrun),
        .o_grant         (o_grant)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int            m_cnt;
    bit            m_pend, m_ovr, m_wrote, m_evolve;
    logic [RB-1:0] m_row;
    logic [W-1:0]  m_set, m_clr;
    int            m_grant;
    int            evolve_seen;
    logic          last_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_pend = 0; m_ovr = 0; m_wrote = 0; m_evolve = 0;
        m_row = '0; m_set = '0; m_clr = '0; m_grant = 0;
    endtask

    task automatic idle_inputs();
        ld_row = '0; ld_set = '0; ld_clear = '0;
        bus_valid = 0; bus_row = '0; bus_set = '0; bus_clear = '0;
        step = 0; clr_ovr = 0;
    endtask

    task automatic check_regs();
        chk("row_select", 64'(o_row_select), 64'(m_row));
        chk("set_cells", 64'(o_set_cells), 64'(m_set));
        chk("clear_cells", 64'(o_clear_cells), 64'(m_clr));
        chk("evolve", 64'(o_evolve), 64'(m_evolve));
        chk("overrun", 64'(o_overrun), 64'(m_ovr));
        chk("grant", 64'(o_grant), 64'(m_grant));
        chk("counter", 64'(dut.u_timer.count_reg), 64'(m_cnt));
        chk("evolve_vs_mask", 64'(o_evolve && ((o_set_cells | o_clear_cells) != '0)), 64'(0));
        if (o_evolve) evolve_seen++;
    endtask

    // One clock: inputs are already driven; check ready mid-cycle, advance model, check registers.
    task automatic cycle();
        bit ld_act, due, req;
        int pe, owner;
        logic exp_ready;
        @(negedge clk);
        ld_act = (ld_set != '0) || (ld_clear != '0);
        exp_ready = reset_n && !ld_act && !(m_pend && !m_wrote);
        last_ready = o_bus_ready;
        chk("bus_ready", 64'(o_bus_ready), 64'(exp_ready));
        if (!reset_n) begin
            model_reset();
        end else begin
            pe  = (period == 0) ? 1 : int'(period);
            due = enable && (m_cnt >= pe - 1);
            req = due || step;
            // owner: 1 loader, 2 evolve, 3 bus, 0 nobody
            if (ld_act) owner = 1;
            else if (m_pend && !m_wrote) owner = 2;
            else if (bus_valid) owner = 3;
            else owner = 0;
            m_ovr = clr_ovr ? 1'b0 : (m_ovr || (req && m_pend));
            if (enable) m_cnt = due ? 0 : m_cnt + 1;
            if (owner == 2) m_pend = 0;
            if (req) m_pend = 1;
            m_evolve = (owner == 2);
            m_grant  = owner;
            m_wrote  = (owner == 1) || (owner == 3);
            m_set = '0; m_clr = '0;
            if (owner == 1) begin
                m_row = ld_row; m_set = ld_set & ~ld_clear; m_clr = ld_clear;
            end else if (owner == 3) begin
                m_row = bus_row; m_set = bus_set & ~bus_clear; m_clr = bus_clear;
            end
        end
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_ready", 64'(o_bus_ready), 64'(0));
        chk("rst_row", 64'(o_row_select), 64'(0));
        chk("rst_set", 64'(o_set_cells), 64'(0));
        chk("rst_clear", 64'(o_clear_cells), 64'(0));
        chk("rst_evolve", 64'(o_evolve), 64'(0));
        chk("rst_overrun", 64'(o_overrun), 64'(0));
        chk("rst_grant", 64'(o_grant), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        enable = 0;
        period = 16'd4;
        @(posedge clk);
        #1;
        apply_reset();

        // Loader/bus collision
        ld_row = 5'd3; ld_set = 32'h1;
        bus_valid = 1; bus_row = 5'd5; bus_set = 32'h10;
        cycle();
        chk("collide_ready", 64'(last_ready), 64'(0));
        chk("collide_ld_row", 64'(o_row_select), 64'(3));
        chk("collide_ld_set", 64'(o_set_cells), 64'(1));
        ld_set = '0;
        cycle();
        chk("collide_bus_ready", 64'(last_ready), 64'(1));
        chk("collide_bus_row", 64'(o_row_select), 64'(5));
        chk("collide_bus_set", 64'(o_set_cells), 64'(32'h10));

        // Mask conflict: clear wins per bit
        bus_set = 32'hF; bus_clear = 32'h3; bus_row = 5'd7;
        cycle();
        chk("conflict_set", 64'(o_set_cells), 64'(32'hC));
        chk("conflict_clear", 64'(o_clear_cells), 64'(32'h3));
        idle_inputs();
        cycle();

        // Step while disabled
        apply_reset();
        period = 16'd100; enable = 1;
        repeat (3) cycle();
        enable = 0;
        evolve_seen = 0;
        step = 1;
        cycle();
        step = 0;
        repeat (4) cycle();
        chk("step_evolves", 64'(evolve_seen), 64'(1));
        chk("step_counter", 64'(dut.u_timer.count_reg), 64'(3));

        // Evolve deferral behind a bus burst on cycles 2..6
        apply_reset();
        period = 16'd4; enable = 1;
        evolve_seen = 0;
        for (int c = 0; c < 10; c++) begin
            bus_valid = (c >= 2) && (c <= 6);
            bus_row   = RB'(c);
            bus_set   = 32'h1 << c;
            cycle();
            if (c == 7) chk("defer_no_evolve_yet", 64'(evolve_seen), 64'(0));
        end
        chk("defer_evolves", 64'(evolve_seen), 64'(1));
        idle_inputs();

        // Overrun under a continuous loader stream
        apply_reset();
        period = 16'd1; enable = 1;
        ld_set = 32'h80; ld_row = 5'd1;
        cycle();
        chk("ovr_first_due", 64'(o_overrun), 64'(0));
        ld_set = 32'h40;
        cycle();
        chk("ovr_second_due", 64'(o_overrun), 64'(1));
        clr_ovr = 1;
        cycle();
        chk("ovr_clear_priority", 64'(o_overrun), 64'(0));
        clr_ovr = 0;
        cycle();
        idle_inputs();

        // Reset mid-burst
        period = 16'd6;
        for (int c = 0; c < 4; c++) begin
            bus_valid = 1; bus_row = RB'(c + 9); bus_set = $urandom;
            cycle();
        end
        apply_reset();
        idle_inputs();
        cycle();
        chk("post_reset_no_write", 64'(o_set_cells | o_clear_cells), 64'(0));
        chk("post_reset_counter", 64'(dut.u_timer.count_reg), 64'(1));

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                apply_reset();
            end
            ld_row  = RB'($urandom);
            ld_set  = ($urandom_range(0, 3) == 0) ? $urandom & $urandom : '0;
            ld_clear = ($urandom_range(0, 5) == 0) ? $urandom & $urandom : '0;
            bus_valid = ($urandom_range(0, 2) != 0);
            bus_row   = RB'($urandom);
            bus_set   = $urandom;
            bus_clear = $urandom & $urandom;
            if ($urandom_range(0, 49) == 0) period = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 29) == 0) enable = ~enable;
            step    = ($urandom_range(0, 19) == 0);
            clr_ovr = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/silife_grid_scheduler.md
# silife_grid_scheduler

Sits between the grid write port and its three users: the SPI grid loader, the bus-side cell writer and the generation timer. It grants the port to one of them per cycle. Loader writes are never stalled. Bus writes use a valid/ready handshake. Generation (evolve) strobes are deferred until the cycle after any write, so a write never collides with an evolve. All grid-facing outputs are registered.

## Interface
- `WIDTH`, 32, cells per row.
- `HEIGHT`, 32, rows per grid segment.
- `ROW_BITS`, `$clog2(HEIGHT)`, row index width.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_ld_row`  in  ROW_BITS  loader row select.
- `i_ld_set`  in  WIDTH  loader set mask; single-cycle pulses.
- `i_ld_clear`  in  WIDTH  loader clear mask; single-cycle pulses.
- `i_bus_valid`  in  1  bus write request.
- `o_bus_ready`  out  1  bus write accepted this cycle.
- `i_bus_row`  in  ROW_BITS  bus row.
- `i_bus_set`  in  WIDTH  bus set mask.
- `i_bus_clear`  in  WIDTH  bus clear mask.
- `i_enable`  in  1  free-running generation timer enable.
- `i_period`  in  16  cycles between generations; 0 is treated as 1.
- `i_step`  in  1  single-generation request pulse; honoured even when `i_enable` is 0.
- `i_clear_overrun`  in  1  clears `o_overrun`.
- `o_row_select`  out  ROW_BITS  grid row.
- `o_set_cells`  out  WIDTH  grid set mask.
- `o_clear_cells`  out  WIDTH  grid clear mask.
- `o_evolve`  out  1  one-cycle generation strobe to the grid.
- `o_overrun`  out  1  sticky: a generation request arrived while one was already pending.
- `o_grant`  out  2  debug: last grant encoding.

## Operation
Loader active: `ld_active = |i_ld_set | |i_ld_clear`.

Fixed priority per cycle: loader > pending evolve > bus > none.
- **Loader grant:** registers `i_ld_*` to the grid outputs. `o_bus_ready` = 0. The evolve stays pending.
- **Evolve grant:** requires `evolve_pending` and no write in the previous cycle (`o_grant` was not loader or bus). Drives `o_evolve` = 1 and clears pending. `o_bus_ready` = 0.
- **Bus grant:** `o_bus_ready` = 1. The write transfers when `i_bus_valid && o_bus_ready`, registering `i_bus_*` to the grid outputs.
- **Idle:** set and clear masks drive 0. `o_row_select` holds its last value.
- `o_bus_ready` is combinational: `!ld_active && !(evolve_pending && !wrote_last)`. Requesters must not make `i_bus_valid` depend on `o_bus_ready`.
- **Mask conflict:** if set and clear masks overlap in one request, clear wins per bit. The forwarded set mask is `set & ~clear`.

Generation timer:
- 16-bit counter, advanced only when `i_enable` = 1.
- When the counter reaches `max(i_period,1)-1`, it wraps to 0 and raises a due event.
- If the counter is at or above `i_period-1` after a period change, it wraps on the next enabled cycle.
- A due event or `i_step` sets `evolve_pending`.
- If pending is already set, or is being cleared that same cycle, `o_overrun` is set. Requests collapse; at most one pending evolve.
- `i_clear_overrun` has priority over a simultaneous new set of `o_overrun`.
- `i_enable` going low freezes the counter value. It does not clear pending.

## Timing
- Grid outputs and `o_evolve` appear 1 cycle after the grant cycle.
- Minimum evolve latency from a due event is 1 cycle; it is later if writes occupy the port.
- There is always at least one idle or non-write cycle between the last write and `o_evolve`.
- Back-to-back bus writes run at 1/cycle when there is no loader activity and no pending evolve.
- **Reset (async assert, sync release):**
  - Outputs: `o_row_select` = 0, `o_set_cells` = 0, `o_clear_cells` = 0, `o_evolve` = 0, `o_overrun` = 0, `o_grant` = none (0).
  - Internal state: counter = 0, pending = 0.
  - `o_bus_ready` is 0 while `reset_n` = 0.
  - Reset mid-burst drops the in-flight write. No partial write is emitted after release.

## Structure
- Shared package `silife_pkg` holds the grant encoding constants `GrantNone`=0, `GrantLoader`=1, `GrantEvolve`=2, `GrantBus`=3.
- One sub-module, `silife_gen_timer`, contains the counter, period clamp, `i_step` merge and due pulse.
- Pending and overrun state stay in the scheduler.

## Test plan
- **Loader/bus collision:** `i_ld_set`=0x1 row 3 and `i_bus_valid` row 5 in the same cycle. Required: `o_bus_ready`=0 that cycle; next cycle outputs row 3 with set 0x1; the bus write row 5 is accepted the following cycle.
- **Evolve deferral:** `i_period`=4, `i_enable`=1, with bus writes on cycles 2–6. Required: `o_evolve` never coincides with a nonzero mask and fires exactly once, in the first non-write slot after the last write.
- **Overrun:** `i_period`=1 with a continuous loader stream. Required: `o_overrun`=1 on the second due event. `i_clear_overrun` clears it; a simultaneous due event still leaves it 0.
- **Step while disabled:** `i_enable`=0 and an `i_step` pulse. Required: exactly one `o_evolve`, and the counter is unchanged.
- **Mask conflict:** bus set=0xF, clear=0x3. Required: grid set=0xC, clear=0x3.
- **Reset mid-stream:** assert `reset_n`=0 during a bus burst. Required: all outputs 0 immediately, no write after release, and the timer restarts from 0.
